// File: rtl/obi_reg_bridge_pkg.sv
// Shared types and constants for the OBI to register-bus bridge.
package obi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Read data returned when a register access is abandoned for lack of ready.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hBADC_AB1E;

  localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/obi_reg_bridge.sv
// OBI slave to simple valid/ready register-bus master, one transaction in flight,
// with a per-access ready timeout and a saturating count of timed-out accesses.
module obi_reg_bridge
  import obi_reg_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [AW-1:0]            obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [DW/8-1:0]          obi_be_i,
  input  logic [DW-1:0]            obi_wdata_i,
  output logic                     obi_rvalid_o,
  output logic [DW-1:0]            obi_rdata_o,
  output logic                     obi_err_o,
  output logic                     reg_valid_o,
  output logic                     reg_write_o,
  output logic [AW-1:0]            reg_addr_o,
  output logic [DW-1:0]            reg_wdata_o,
  output logic [DW/8-1:0]          reg_wstrb_o,
  input  logic                     reg_ready_i,
  input  logic [DW-1:0]            reg_rdata_i,
  input  logic                     reg_error_i,
  output logic                     busy_o,
  output logic [TIMEOUT_CNT_W-1:0] timeout_cnt_o,
  output state_e                   dbg_state_o
);

  // Handshakes: OBI request is accepted in the cycle req & gnt are both high;
  // a register access completes in the cycle reg_valid_o & reg_ready_i are both high;
  // the OBI response is the single cycle obi_rvalid_o is high (no back-pressure).

  localparam int BW  = DW / 8;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     w_accept;
  logic                     w_timeout;
  logic [AW-1:0]            r_addr;
  logic                     r_we;
  logic [BW-1:0]            r_be;
  logic [DW-1:0]            r_wdata;
  logic [DW-1:0]            r_rdata;
  logic                     r_err;
  logic [WCW-1:0]           r_wait;
  logic [TIMEOUT_CNT_W-1:0] r_timeout_cnt;

  always_comb begin
    w_state_next = r_state;
    obi_gnt_o    = 1'b0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (reg_ready_i) begin
          w_state_next = ST_RESP;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_wait        <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= obi_addr_i;
        r_we    <= obi_we_i;
        r_be    <= obi_be_i;
        r_wdata <= obi_wdata_i;
        r_wait  <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (reg_ready_i) begin
          r_rdata <= r_we ? '0 : reg_rdata_i;
          r_err   <= reg_error_i;
        end else begin
          r_wait <= r_wait + WCW'(1);
          if (w_timeout) begin
            r_rdata <= r_we ? '0 : DW'(TIMEOUT_RDATA);
            r_err   <= 1'b1;
            if (r_timeout_cnt != '1) r_timeout_cnt <= r_timeout_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign obi_rvalid_o  = (r_state == ST_RESP);
  assign obi_rdata_o   = obi_rvalid_o ? r_rdata : '0;
  assign obi_err_o     = obi_rvalid_o ? r_err : 1'b0;
  assign reg_valid_o   = (r_state == ST_ACCESS);
  assign reg_write_o   = r_we;
  assign reg_addr_o    = r_addr;
  assign reg_wdata_o   = r_wdata;
  assign reg_wstrb_o   = r_we ? r_be : '1;
  assign busy_o        = (r_state != ST_IDLE);
  assign timeout_cnt_o = r_timeout_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_obi_reg_bridge.sv
// Directed bench for obi_reg_bridge: latency, write strobes, timeout, ready-vs-timeout
// race, back-to-back requests and mid-transaction reset.
module tb_obi_reg_bridge;
  import obi_reg_bridge_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        busy;
  logic [7:0]  timeout_cnt;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  obi_reg_bridge #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .busy_o(busy), .timeout_cnt_o(timeout_cnt), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one OBI transaction from IDLE; the slave raises ready on ACCESS cycle
  // ready_at (counted from 0), or never if ready_at >= TO.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int ready_at,
                         input logic [31:0] slv_rdata, input logic slv_err,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int  cyc;
    bit  done;
    logic [31:0] exp_d;
    obi_req   = 1'b1;
    obi_we    = we;
    obi_addr  = addr;
    obi_be    = be;
    obi_wdata = wdata;
    @(negedge clk);
    chk("gnt_idle", obi_gnt, 1'b1);
    tick();
    obi_req   = 1'b0;
    obi_addr  = '0;
    obi_wdata = '0;
    exp_q.push_back(exp_rdata);
    cyc  = 0;
    done = 0;
    while (!done && cyc < TO + 4) begin
      reg_ready = (cyc == ready_at);
      reg_rdata = slv_rdata;
      reg_error = slv_err;
      @(negedge clk);
      chk("reg_valid", reg_valid, 1'b1);
      chk("rvalid_in_access", obi_rvalid, 1'b0);
      if (cyc == 0) begin
        chk("reg_addr", reg_addr, addr);
        chk("reg_write", reg_write, we);
        chk("reg_wdata", reg_wdata, wdata);
        chk("reg_wstrb", reg_wstrb, we ? be : 4'hF);
        chk("busy_access", busy, 1'b1);
        chk("gnt_access", obi_gnt, 1'b0);
      end
      tick();
      if (cyc == ready_at || cyc == TO - 1) done = 1;
      cyc++;
    end
    reg_ready = 1'b0;
    reg_rdata = '0;
    reg_error = 1'b0;
    @(negedge clk);
    exp_d = exp_q.pop_front();
    chk("rvalid", obi_rvalid, 1'b1);
    chk("rdata", obi_rdata, exp_d);
    chk("err", obi_err, exp_err);
    chk("reg_valid_resp", reg_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("rvalid_drop", obi_rvalid, 1'b0);
    chk("rdata_zero", obi_rdata, 32'h0);
    chk("err_zero", obi_err, 1'b0);
    chk("busy_idle", busy, 1'b0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    obi_req   = 1'b0;
    obi_addr  = '0;
    obi_we    = 1'b0;
    obi_be    = '0;
    obi_wdata = '0;
    reg_ready = 1'b0;
    reg_rdata = '0;
    reg_error = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_gnt", obi_gnt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", obi_rvalid, 1'b0);
    chk("rst_reg_valid", reg_valid, 1'b0);
    chk("rst_tocnt", timeout_cnt, 8'd0);
    tick();

    // read, ready after three wait cycles
    run_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
    // write, ready immediately; slave rdata must not leak into the response
    run_txn(1'b1, 32'h2000_0010, 4'b0011, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    // read with slave error
    run_txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, 32'h0BAD_0BAD, 1'b1);
    chk("tocnt_before", timeout_cnt, 8'd0);
    // read, ready never arrives
    run_txn(1'b0, 32'h0000_0200, 4'hF, 32'h0, 100, 32'h5555_5555, 1'b0, 32'hBADC_AB1E, 1'b1);
    chk("tocnt_after_to", timeout_cnt, 8'd1);
    // write that times out returns zero data
    run_txn(1'b1, 32'h0000_0204, 4'b1000, 32'h1111_2222, 100, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("tocnt_after_to_wr", timeout_cnt, 8'd2);
    // ready on the exact timeout cycle wins
    run_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, TO - 1, 32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0);
    chk("tocnt_race", timeout_cnt, 8'd2);

    // back-to-back: req held high, ready held high
    obi_req   = 1'b1;
    obi_we    = 1'b0;
    obi_addr  = 32'h0000_0400;
    reg_ready = 1'b1;
    reg_rdata = 32'hA5A5_0001;
    @(negedge clk); chk("b2b_gnt_n", obi_gnt, 1'b1);
    tick();
    @(negedge clk); chk("b2b_gnt_acc", obi_gnt, 1'b0);
    chk("b2b_valid_acc", reg_valid, 1'b1);
    tick();
    @(negedge clk); chk("b2b_gnt_resp", obi_gnt, 1'b0);
    chk("b2b_rvalid1", obi_rvalid, 1'b1);
    chk("b2b_rdata1", obi_rdata, 32'hA5A5_0001);
    tick();
    reg_rdata = 32'hA5A5_0002;
    @(negedge clk); chk("b2b_gnt_second", obi_gnt, 1'b1);
    chk("b2b_rvalid_gap", obi_rvalid, 1'b0);
    tick();
    obi_req = 1'b0;
    @(negedge clk); chk("b2b_valid2", reg_valid, 1'b1);
    tick();
    @(negedge clk); chk("b2b_rvalid2", obi_rvalid, 1'b1);
    chk("b2b_rdata2", obi_rdata, 32'hA5A5_0002);
    tick();
    reg_ready = 1'b0;
    reg_rdata = '0;
    @(negedge clk); chk("b2b_idle", busy, 1'b0);
    tick();

    // reset during ACCESS abandons the transaction
    obi_req  = 1'b1;
    obi_addr = 32'h0000_0500;
    tick();
    obi_req = 1'b0;
    @(negedge clk); chk("rstmid_access", reg_valid, 1'b1);
    chk("rstmid_tocnt_pre", timeout_cnt, 8'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_reg_valid", reg_valid, 1'b0);
    chk("rstmid_tocnt", timeout_cnt, 8'd0);
    chk("rstmid_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_no_rvalid", obi_rvalid, 1'b0);
      tick();
      @(negedge clk);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_reg_bridge.md
OBI_REG_BRIDGE -- requirements
Module: obi_reg_bridge

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (byte-enable width DW/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, range 2..65535, meaning max cycles a register access may wait for ready.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  sync active-high reset.
REQ-005 SHALL have these OBI slave ports: obi_req_i  in  1  request; obi_gnt_o  out  1  grant; obi_addr_i  in  AW  address; obi_we_i  in  1  write enable; obi_be_i  in  DW/8  byte enables; obi_wdata_i  in  DW  write data; obi_rvalid_o  out  1  response valid; obi_rdata_o  out  DW  read data; obi_err_o  out  1  response error.
REQ-006 SHALL have these register-bus master ports: reg_valid_o  out  1  access valid; reg_write_o  out  1  write; reg_addr_o  out  AW  address; reg_wdata_o  out  DW  write data; reg_wstrb_o  out  DW/8  strobes; reg_ready_i  in  1  access done; reg_rdata_i  in  DW  read data; reg_error_i  in  1  slave error.
REQ-007 SHALL have status ports: busy_o  out  1  transaction in flight; timeout_cnt_o  out  8  saturating count of timed-out accesses.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one transaction outstanding at a time.
REQ-009 In IDLE, obi_gnt_o SHALL equal obi_req_i combinationally; gnt in any other state SHALL be 0.
REQ-010 On req&gnt, addr/we/be/wdata SHALL be registered and FSM SHALL enter ACCESS next cycle.
REQ-011 In ACCESS, reg_valid_o SHALL be 1 and reg_* SHALL hold the registered fields stable until the state is left.
REQ-012 In ACCESS with reg_ready_i=1, reg_rdata_i (reads) or 0 (writes) and reg_error_i SHALL be captured; FSM SHALL enter RESP.
REQ-013 In RESP, obi_rvalid_o SHALL be 1 for exactly one cycle with captured rdata/err; FSM SHALL return to IDLE.
REQ-014 Minimum latency: gnt cycle N, reg_valid_o from N+1, ready at N+1 gives rvalid at N+2.
REQ-015 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ready.
REQ-016 If ACCESS lasts TIMEOUT cycles without ready, FSM SHALL enter RESP with obi_err_o=1, obi_rdata_o=32'hBADCAB1E (reads) or 0 (writes), and timeout_cnt_o SHALL increment, saturating at 255.
REQ-017 If reg_ready_i arrives in the same cycle the timeout would fire, ready SHALL win (no error, no count).
REQ-018 obi_rdata_o and obi_err_o SHALL be 0 whenever obi_rvalid_o is 0.
REQ-019 busy_o SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-020 reg_wstrb_o SHALL be obi_be_i for writes and all-ones for reads.

Reset
REQ-021 While rst_i=1 at a clock edge: FSM to IDLE, wait counter and timeout_cnt_o to 0, all registered outputs to 0.
REQ-022 Reset asserted mid-transaction SHALL abandon it: no rvalid generated afterwards, reg_valid_o 0 the cycle after reset.

Structure
REQ-023 FSM state enum and the timeout read pattern constant SHALL live in a shared package obi_reg_bridge_pkg.
REQ-024 The design SHALL be a single module with no sub-modules; wait counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-025 Read, ready after 3 wait cycles, rdata 32'h1234_5678 -> rvalid one cycle, rdata 32'h1234_5678, err 0.
REQ-026 Write addr 32'h2000_0010, be 4'b0011, ready immediately -> reg_wstrb_o 4'b0011, rvalid at N+2, rdata 0.
REQ-027 Read, TIMEOUT=8, ready never -> rvalid after 8 ACCESS cycles, rdata 32'hBADCAB1E, err 1, timeout_cnt_o 1.
REQ-028 Ready on the exact timeout cycle -> err 0, timeout_cnt_o unchanged.
REQ-029 Back-to-back req held high -> gnt only in IDLE, second request accepted the cycle after rvalid.
REQ-030 rst_i pulsed during ACCESS -> no rvalid, reg_valid_o 0, timeout_cnt_o 0.
